// File: rtl/button_led_pkg.sv
// Shared types and helpers for the board LED controller: mode encoding,
// default timing constants and counter-width derivation.
package button_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_SOC   = 2'd3
  } mode_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_STEP_CYCLES     = 12_500_000;

  localparam logic [3:0] SCAN_ENTRY = 4'b0001;

  // Width of a counter that must hold 0..cycles-1 (at least one bit)
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  // Mode sequence OFF -> COUNT -> SCAN -> SOC -> OFF
  function automatic mode_t next_mode(input mode_t m);
    mode_t r;
    case (m)
      MODE_OFF:   r = MODE_COUNT;
      MODE_COUNT: r = MODE_SCAN;
      MODE_SCAN:  r = MODE_SOC;
      default:    r = MODE_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes one active-low raw push-button, debounces it and emits a
// single-cycle press pulse on each accepted 1->0 level change.
module button_debounce
  import button_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_in,
  output logic level_out,
  output logic press_out
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; flip on the last one
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounce counter and press pulse registers; idle state is "released"
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_out = level_q;
  assign press_out = press_q;

endmodule

// File: rtl/button_led_ctrl.sv
// Board LED controller: two debounced buttons select one of four LED modes
// (off, binary count, bouncing scan, SoC pass-through) and pause stepping.
module button_led_ctrl
  import button_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int STEP_CYCLES     = DEFAULT_STEP_CYCLES
) (
  input  logic       io_systemClk,
  input  logic       io_asyncResetn,
  input  logic [1:0] butons,
  input  logic [3:0] soc_leds,
  output logic [3:0] leds,
  output logic [1:0] mode,
  output logic       paused
);

  localparam int            PW         = cnt_width(STEP_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);

  logic [1:0]    btn_level;
  logic [1:0]    btn_press;
  logic          mode_press;
  logic          pause_press;
  logic          tick;
  logic          mode_change;

  mode_t         mode_q, mode_d;
  logic          paused_q, paused_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    count_q, count_d, count_step;
  logic [3:0]    scan_q, scan_d, scan_step;
  logic          scan_up_q, scan_up_d, scan_up_step;
  logic [3:0]    leds_q, leds_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk       (io_systemClk),
    .resetn    (io_asyncResetn),
    .raw_in    (butons[0]),
    .level_out (btn_level[0]),
    .press_out (btn_press[0])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_btn (
    .clk       (io_systemClk),
    .resetn    (io_asyncResetn),
    .raw_in    (butons[1]),
    .level_out (btn_level[1]),
    .press_out (btn_press[1])
  );

  // A press only counts while the debounced level reads "pressed"
  assign mode_press  = btn_press[0] & ~btn_level[0];
  assign pause_press = btn_press[1] & ~btn_level[1];

  assign tick = ~paused_q && (presc_q == PRESC_LAST);

  // Mode FSM, pause toggle and prescaler; a mode change overrides a same-cycle pause press
  always_comb begin
    mode_d      = mode_q;
    paused_d    = paused_q;
    presc_d     = presc_q;
    mode_change = 1'b0;
    if (!paused_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (pause_press) begin
      paused_d = ~paused_q;
      if (paused_q) begin
        presc_d = '0;
      end
    end
    if (mode_press) begin
      mode_d      = next_mode(mode_q);
      paused_d    = 1'b0;
      presc_d     = '0;
      mode_change = 1'b1;
    end
  end

  // Pattern stepping and LED mux; LEDs register the post-tick value so they move one clock after tick
  always_comb begin
    count_step   = count_q;
    scan_step    = scan_q;
    scan_up_step = scan_up_q;
    if (tick && (mode_q == MODE_COUNT)) begin
      count_step = count_q + 4'd1;
    end
    if (tick && (mode_q == MODE_SCAN)) begin
      if (scan_up_q) begin
        if (scan_q[3]) begin
          scan_step    = 4'b0100;
          scan_up_step = 1'b0;
        end else begin
          scan_step = scan_q << 1;
        end
      end else begin
        if (scan_q[0]) begin
          scan_step    = 4'b0010;
          scan_up_step = 1'b1;
        end else begin
          scan_step = scan_q >> 1;
        end
      end
    end
    count_d   = mode_change ? 4'd0 : count_step;
    scan_d    = mode_change ? SCAN_ENTRY : scan_step;
    scan_up_d = mode_change ? 1'b1 : scan_up_step;
    case (mode_q)
      MODE_COUNT: leds_d = count_step;
      MODE_SCAN:  leds_d = scan_step;
      MODE_SOC:   leds_d = soc_leds;
      default:    leds_d = 4'b0000;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge io_systemClk) begin
    if (!io_asyncResetn) begin
      mode_q    <= MODE_OFF;
      paused_q  <= 1'b0;
      presc_q   <= '0;
      count_q   <= 4'd0;
      scan_q    <= SCAN_ENTRY;
      scan_up_q <= 1'b1;
      leds_q    <= 4'b0000;
    end else begin
      mode_q    <= mode_d;
      paused_q  <= paused_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      scan_q    <= scan_d;
      scan_up_q <= scan_up_d;
      leds_q    <= leds_d;
    end
  end

  assign leds   = leds_q;
  assign mode   = mode_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_button_led_ctrl.sv
// Testbench for button_led_ctrl: directed scenarios plus randomized button
// activity, all checked every cycle against a behavioural reference model.
module tb_button_led_ctrl;

  localparam int DB = 4;
  localparam int ST = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] butons = 2'b11;
  logic [3:0] soc_leds = 4'b0000;
  logic [3:0] leds;
  logic [1:0] mode;
  logic       paused;

  int tests_run = 0;
  int tests_failed = 0;
  bit check_en = 1'b0;
  logic [3:0] rec_q[$];

  button_led_ctrl #(.DEBOUNCE_CYCLES(DB), .STEP_CYCLES(ST)) dut (
    .io_systemClk   (clk),
    .io_asyncResetn (resetn),
    .butons         (butons),
    .soc_leds       (soc_leds),
    .leds           (leds),
    .mode           (mode),
    .paused         (paused)
  );

  always #5 clk = ~clk;

  // Reference model state: mode index, pause flag, cycles since prescaler restart, ticks since mode entry
  int         m_mode = 0;
  int         m_ph = 0;
  int         m_ticks = 0;
  bit         m_paused = 1'b0;
  logic [3:0] m_leds = 4'b0000;
  bit   [1:0] m_press = 2'b00;
  bit   [1:0] m_level = 2'b11;
  logic [DB:0] m_hist [2];

  function automatic logic [3:0] pattern(input int md, input int t, input logic [3:0] s);
    int scan_tab [6];
    scan_tab = '{1, 2, 4, 8, 4, 2};
    case (md)
      1:       return 4'(t % 16);
      2:       return 4'(scan_tab[t % 6]);
      3:       return s;
      default: return 4'b0000;
    endcase
  endfunction

  // Behavioural model: button accepted once its last DB synchronized samples all disagree with the accepted level
  always @(posedge clk) begin : ref_model
    bit tick;
    bit all_diff;
    bit [1:0] new_press;
    if (!resetn) begin
      m_mode = 0; m_ph = 0; m_ticks = 0; m_paused = 1'b0; m_leds = 4'b0000;
      m_press = 2'b00; m_level = 2'b11;
      m_hist[0] = '1; m_hist[1] = '1;
    end else begin
      tick = !m_paused && (m_ph == ST - 1);
      if (tick && (m_mode == 1 || m_mode == 2)) m_ticks++;
      m_leds = pattern(m_mode, m_ticks, soc_leds);
      if (m_press[0]) begin
        m_mode = (m_mode + 1) % 4; m_paused = 1'b0; m_ph = 0; m_ticks = 0;
      end else begin
        if (!m_paused) m_ph = tick ? 0 : m_ph + 1;
        if (m_press[1]) begin
          if (m_paused) m_ph = 0;
          m_paused = !m_paused;
        end
      end
      new_press = 2'b00;
      for (int b = 0; b < 2; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DB; k++) if (m_hist[b][k] == m_level[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[b] = !m_level[b];
          new_press[b] = !m_level[b];
        end
        m_hist[b] = {m_hist[b][DB-1:0], butons[b]};
      end
      m_press = new_press;
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_leds", 8'(leds), 8'(m_leds));
      checkOutput("model_mode", 8'(mode), 8'(m_mode));
      checkOutput("model_paused", 8'(paused), 8'(m_paused));
    end
  end

  task automatic applyStimulus(input logic [1:0] b, input logic [3:0] s, input int n);
    butons = b;
    soc_leds = s;
    repeat (n) @(negedge clk);
  endtask

  // Hold the selected buttons low long enough to register, then release (returns just after the mode edge)
  task automatic pressButton(input logic [1:0] which);
    applyStimulus(~which, soc_leds, 7);
    butons = 2'b11;
  endtask

  task automatic recordChanges(input int n);
    rec_q.delete();
    rec_q.push_back(leds);
    repeat (n) begin
      @(negedge clk);
      if (leds !== rec_q[$]) rec_q.push_back(leds);
    end
  endtask

  task automatic checkSequence(input string tag, input int exp_vals[$]);
    logic [3:0] got;
    for (int i = 0; i < exp_vals.size(); i++) begin
      got = (i < rec_q.size()) ? rec_q[i] : 4'bxxxx;
      checkOutput($sformatf("%s[%0d]", tag, i), 8'(got), 8'(exp_vals[i]));
    end
  endtask

  initial begin
    int seq[$];
    int waited;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_leds", 8'(leds), 8'h0);
    checkOutput("rst_mode", 8'(mode), 8'h0);
    checkOutput("rst_paused", 8'(paused), 8'h0);
    resetn = 1'b1;
    applyStimulus(2'b11, 4'h0, 100);
    checkOutput("idle_mode", 8'(mode), 8'h0);

    // Short bounces on MODE are ignored
    repeat (4) begin
      applyStimulus(2'b10, 4'h0, 3);
      applyStimulus(2'b11, 4'h0, 3);
    end
    applyStimulus(2'b11, 4'h0, 10);
    checkOutput("bounce_mode", 8'(mode), 8'h0);

    // Long press: mode changes exactly 7 cycles after the fall
    applyStimulus(2'b10, 4'h0, 6);
    checkOutput("press_mode_c6", 8'(mode), 8'h0);
    applyStimulus(2'b10, 4'h0, 1);
    checkOutput("press_mode_c7", 8'(mode), 8'h1);
    applyStimulus(2'b10, 4'h0, 3);
    applyStimulus(2'b11, 4'h0, 12);

    // Re-press into SCAN and watch the bounce sequence
    pressButton(2'b01);
    checkOutput("scan_mode", 8'(mode), 8'h2);
    @(negedge clk);
    recordChanges(70);
    seq = '{1, 2, 4, 8, 4, 2, 1, 2};
    checkSequence("scan_seq", seq);

    // SOC pass-through, including while paused
    pressButton(2'b01);
    applyStimulus(2'b11, 4'b1010, 1);
    checkOutput("soc_1010", 8'(leds), 8'hA);
    pressButton(2'b10);
    applyStimulus(2'b11, 4'b1010, 10);
    checkOutput("soc_paused", 8'(paused), 8'h1);
    applyStimulus(2'b11, 4'b0101, 1);
    checkOutput("soc_paused_0101", 8'(leds), 8'h5);
    repeat (20) applyStimulus(2'b11, 4'($urandom_range(0, 15)), 1);

    // OFF then COUNT; count through a full wrap
    pressButton(2'b01);
    applyStimulus(2'b11, 4'h0, 12);
    checkOutput("off_leds", 8'(leds), 8'h0);
    pressButton(2'b01);
    @(negedge clk);
    recordChanges(140);
    seq.delete();
    for (int i = 0; i < 18; i++) seq.push_back(i % 16);
    checkSequence("count_seq", seq);

    // Pause at 0101, hold, resume
    waited = 0;
    while (leds !== 4'b0101 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reach_0101", 8'(leds), 8'h5);
    pressButton(2'b10);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("pause_hold", 8'(leds), 8'h5);
    end
    pressButton(2'b10);
    repeat (7) @(negedge clk);
    checkOutput("resume_c7", 8'(leds), 8'h5);
    @(negedge clk);
    checkOutput("resume_c8", 8'(leds), 8'h6);

    // Simultaneous MODE+PAUSE while paused: mode advances, pause clears
    pressButton(2'b10);
    applyStimulus(2'b11, 4'h0, 10);
    checkOutput("pre_both_paused", 8'(paused), 8'h1);
    pressButton(2'b11);
    checkOutput("both_mode", 8'(mode), 8'h2);
    checkOutput("both_paused", 8'(paused), 8'h0);
    applyStimulus(2'b11, 4'h0, 12);

    // Reset mid-debounce, then a still-held button is accepted after DB+3 clocks
    applyStimulus(2'b10, 4'h0, 3);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("midrst_leds", 8'(leds), 8'h0);
    checkOutput("midrst_mode", 8'(mode), 8'h0);
    checkOutput("midrst_paused", 8'(paused), 8'h0);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("held_mode_c6", 8'(mode), 8'h0);
    @(negedge clk);
    checkOutput("held_mode_c7", 8'(mode), 8'h1);
    applyStimulus(2'b11, 4'h0, 12);

    // Randomized button activity, SoC data and occasional resets
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 40) == 0) begin
        resetn = 1'b0;
        applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(1, 3));
        resetn = 1'b1;
      end
      applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(1, 14));
    end
    applyStimulus(2'b11, 4'h0, 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/button_led_ctrl.md
# button_led_ctrl

Board-level LED controller for the Lab top level. It debounces the two push-buttons and steps a four-mode LED sequencer: off, binary counter, bouncing scan, and SoC pass-through. Button presses select the mode and pause or resume stepping. It sits between the `butons`/`leds` pins and the SoC GPIO, so the four LEDs are shared between hardware patterns and software.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples required to accept a button level change (20 ms at 50 MHz).
- `STEP_CYCLES`, default 12_500_000: clocks per pattern step (0.25 s at 50 MHz).
- `io_systemClk`  in  1  system clock; the only clock.
- `io_asyncResetn`  in  1  reset; synchronous and active-low, sampled on `io_systemClk`.
- `butons`  in  2  raw push-buttons, active-low, asynchronous to the clock. Bit 0 is MODE, bit 1 is PAUSE.
- `soc_leds`  in  4  LED value from SoC GPIO, synchronous to `io_systemClk`.
- `leds`  out  4  registered LED drive, active-high.
- `mode`  out  2  current mode: 0 OFF, 1 COUNT, 2 SCAN, 3 SOC.
- `paused`  out  1  stepping is frozen.

## Operation
- **Button conditioning.** Each button passes through a 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synchronized level differs from the debounced level.
  - It clears whenever the levels match.
  - On reaching `DEBOUNCE_CYCLES` mismatched samples, the debounced level flips and the counter clears.
  - A press is a 1-cycle pulse on a debounced 1→0 transition. Release generates nothing.
  - Bounces shorter than `DEBOUNCE_CYCLES` are ignored.
- **Mode FSM.** A MODE press advances OFF→COUNT→SCAN→SOC→OFF.
  - Every mode change clears the prescaler, the pattern state and `paused`.
- **Pause.** A PAUSE press toggles `paused`.
  - While paused, the prescaler and pattern state hold.
  - In SOC mode, `leds` still follows `soc_leds`.
- **Simultaneous presses.** If MODE and PAUSE press in the same cycle, the mode advances and `paused` ends at 0; the mode change wins.
- **Prescaler.** Counts 0..`STEP_CYCLES`-1 and wraps. `tick` asserts in the cycle the count equals `STEP_CYCLES`-1 and `paused`=0.
- **Per-mode behaviour:**
  - OFF: `leds`=0000.
  - COUNT: a 4-bit counter starts at 0 and increments on `tick`, wrapping 1111→0000. `leds` shows the counter.
  - SCAN: one-hot sequence 0001,0010,0100,1000,0100,0010,0001,… Direction reverses at each end and each end is shown once, never twice consecutively. Entry value is 0001.
  - SOC: `leds` = `soc_leds`, registered.
- **Reset values:** `leds`=0000, `mode`=0 (OFF), `paused`=0. Debounced levels reset to 1 (released), counters to 0, synchronizer flops to 1.
- **Reset during operation:** asserting reset mid-press or mid-pattern returns everything to the reset values on the next edge. A button still held low when reset releases is accepted as a press after `DEBOUNCE_CYCLES`+3 clocks.

## Timing
- Pin change at cycle 0 produces a press pulse in cycle `DEBOUNCE_CYCLES`+2.
  - `mode` updates at cycle `DEBOUNCE_CYCLES`+3.
  - `leds` shows the new mode's entry value at cycle `DEBOUNCE_CYCLES`+4.
- First tick after mode entry or resume occurs `STEP_CYCLES` clocks after the prescaler restarts from 0. `leds` updates 1 clock after the tick.
- SOC pass-through latency is 1 clock from `soc_leds` to `leds`.
- `paused` changes 1 clock after the PAUSE press pulse.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `button_led_pkg` holds:
  - mode encodings `MODE_OFF`, `MODE_COUNT`, `MODE_SCAN`, `MODE_SOC`;
  - the 2-bit mode type;
  - counter widths derived from the parameters with `$clog2`.
- Sub-module `button_debounce`, instantiated once per button.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: clk, resetn, raw in, debounced level out, press pulse out.
- The top holds the mode FSM, pause flag, prescaler, pattern registers and output mux.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `STEP_CYCLES`=8.
- **Reset:** hold reset 3 cycles with `butons`=11 → `leds`=0000, `mode`=0, `paused`=0; nothing changes over 100 idle cycles.
- **Debounce:** drive `butons[0]` low for 3 cycles, then high, repeated → `mode` stays 0. Then hold low 10 cycles → `mode`=1 exactly 7 cycles after the fall; release and re-press → `mode`=2.
- **COUNT wrap:** in COUNT, run 17×8 cycles → `leds` steps 0,1,…,15,0,1, one step every 8 clocks.
- **SCAN bounce:** in SCAN, run 7 ticks → `leds` sequence 0001,0010,0100,1000,0100,0010,0001,0010; no repeated 1000.
- **Pause and simultaneous presses:**
  - In COUNT at `leds`=0101, press PAUSE → value holds for 50 cycles; press again → 0110 after 8 clocks.
  - Press both buttons in the same cycle → `mode` advances and `paused`=0.
- **SOC pass-through and mid-operation reset:**
  - In SOC, `soc_leds`=1010 → `leds`=1010 one clock later, including while `paused`=1.
  - Assert reset mid-debounce → all outputs return to reset values on the next edge.
